// File: rtl/hamfsk_pkg.sv
// ============================================================================
// Module  : hamfsk_pkg
// Brief   : Hamming(7,4) layout constants and helper functions for the FSK link
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hamfsk_pkg;

    localparam int HAM_CW_W    = 7;
    localparam int HAM_FRAME_W = 14;
    localparam int PCM_W       = 8;

    // Bit positions inside one 7-bit codeword; shared with the upstream encoder.
    localparam int HAM_P1_POS = 0;
    localparam int HAM_P2_POS = 1;
    localparam int HAM_D1_POS = 2;
    localparam int HAM_P4_POS = 3;
    localparam int HAM_D2_POS = 4;
    localparam int HAM_D3_POS = 5;
    localparam int HAM_D4_POS = 6;

    function automatic logic [2:0] ham_syndrome(input logic [HAM_CW_W-1:0] w);
        logic s1, s2, s4;
        s1 = w[HAM_P1_POS] ^ w[HAM_D1_POS] ^ w[HAM_D2_POS] ^ w[HAM_D4_POS];
        s2 = w[HAM_P2_POS] ^ w[HAM_D1_POS] ^ w[HAM_D3_POS] ^ w[HAM_D4_POS];
        s4 = w[HAM_P4_POS] ^ w[HAM_D2_POS] ^ w[HAM_D3_POS] ^ w[HAM_D4_POS];
        return {s4, s2, s1};
    endfunction

    function automatic logic [3:0] ham_data(input logic [HAM_CW_W-1:0] w);
        return {w[HAM_D4_POS], w[HAM_D3_POS], w[HAM_D2_POS], w[HAM_D1_POS]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hamming74_correct.sv
// ============================================================================
// Module  : hamming74_correct
// Brief   : Combinational single-error correction of one Hamming(7,4) codeword
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming74_correct
    import hamfsk_pkg::*;
(
    input  logic [HAM_CW_W-1:0] i_codeword,
    output logic [3:0]          o_nibble,
    output logic                o_err
);

    logic [2:0]          w_syn;
    logic [HAM_CW_W-1:0] w_flip;
    logic [HAM_CW_W-1:0] w_fixed;

    // A nonzero syndrome is the 1-based index of the bit to invert.
    assign w_syn   = ham_syndrome(i_codeword);
    assign w_flip  = (w_syn == 3'd0) ? '0 : (7'd1 << (w_syn - 3'd1));
    assign w_fixed = i_codeword ^ w_flip;

    assign o_nibble = ham_data(w_fixed);
    assign o_err    = |w_syn;

endmodule

`default_nettype wire

// File: rtl/hamming_frame_decoder.sv
// ============================================================================
// Module  : hamming_frame_decoder
// Brief   : Two-stage valid/ready decoder of 14-bit Hamcode frames to PCM bytes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_frame_decoder
    import hamfsk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [HAM_FRAME_W-1:0] in_hamcode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clr_stats,
    output logic [PCM_W-1:0]       pcm_data,
    output logic                   err_lo,
    output logic                   err_hi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       corr_count,
    output logic [CNT_W-1:0]       frame_count
);

    logic                   r_s1_valid;
    logic [HAM_FRAME_W-1:0] r_s1_code;
    logic [2:0]             r_s1_syn_lo;
    logic [2:0]             r_s1_syn_hi;

    logic                   r_s2_valid;
    logic [PCM_W-1:0]       r_pcm;
    logic                   r_err_lo;
    logic                   r_err_hi;

    logic [CNT_W-1:0]       r_corr_count;
    logic [CNT_W-1:0]       r_frame_count;

    logic w_s2_en, w_s1_en, w_accept, w_move, w_deliver;
    logic [3:0] w_nib_lo, w_nib_hi;
    logic       w_fix_lo, w_fix_hi;
    logic [1:0]     w_corr_inc;
    logic [CNT_W:0] w_corr_sum;

    assign w_s2_en   = !r_s2_valid | out_ready;
    assign w_s1_en   = !r_s1_valid | w_s2_en;
    assign w_accept  = in_valid & w_s1_en;
    assign w_move    = r_s1_valid & w_s2_en;
    assign w_deliver = r_s2_valid & out_ready;

    hamming74_correct u_corr_lo (
        .i_codeword (r_s1_code[HAM_CW_W-1:0]),
        .o_nibble   (w_nib_lo),
        .o_err      (w_fix_lo)
    );

    hamming74_correct u_corr_hi (
        .i_codeword (r_s1_code[HAM_FRAME_W-1:HAM_CW_W]),
        .o_nibble   (w_nib_hi),
        .o_err      (w_fix_hi)
    );

    // Counter increment comes from the syndromes captured in stage 1.
    assign w_corr_inc = w_move ? ({1'b0, |r_s1_syn_lo} + {1'b0, |r_s1_syn_hi}) : 2'd0;
    assign w_corr_sum = {1'b0, r_corr_count} + {{(CNT_W-1){1'b0}}, w_corr_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_code   <= '0;
            r_s1_syn_lo <= 3'd0;
            r_s1_syn_hi <= 3'd0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_code   <= in_hamcode;
                r_s1_syn_lo <= ham_syndrome(in_hamcode[HAM_CW_W-1:0]);
                r_s1_syn_hi <= ham_syndrome(in_hamcode[HAM_FRAME_W-1:HAM_CW_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_pcm      <= '0;
            r_err_lo   <= 1'b0;
            r_err_hi   <= 1'b0;
        end else begin
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_move) begin
                r_pcm    <= {w_nib_hi, w_nib_lo};
                r_err_lo <= w_fix_lo;
                r_err_hi <= w_fix_hi;
            end
        end
    end

    // Any carry out of the sum means the true count passed the maximum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_corr_count  <= '0;
            r_frame_count <= '0;
        end else if (clr_stats) begin
            r_corr_count  <= '0;
            r_frame_count <= '0;
        end else begin
            r_corr_count  <= w_corr_sum[CNT_W] ? {CNT_W{1'b1}} : w_corr_sum[CNT_W-1:0];
            if (w_deliver) begin
                r_frame_count <= r_frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready    = w_s1_en;
    assign out_valid   = r_s2_valid;
    assign pcm_data    = r_pcm;
    assign err_lo      = r_err_lo;
    assign err_hi      = r_err_hi;
    assign corr_count  = r_corr_count;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_hamming_frame_decoder.sv
// ============================================================================
// Module  : tb_hamming_frame_decoder
// Brief   : Randomized scoreboard bench for hamming_frame_decoder (CNT_W=2)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_frame_decoder;

    localparam int C_CNT_W = 2;
    localparam int C_CNT_MAX = (1 << C_CNT_W) - 1;

    typedef struct {
        logic [7:0] pcm;
        logic       elo;
        logic       ehi;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [13:0]        in_hamcode = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               clr_stats = 1'b0;
    logic [7:0]         pcm_data;
    logic               err_lo;
    logic               err_hi;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [C_CNT_W-1:0] corr_count;
    logic [C_CNT_W-1:0] frame_count;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   delivered = 0;
    int   entered = 0;
    int   m_corr = 0;
    int   m_frame = 0;
    bit   pend_out = 1'b0;
    bit   pend_clr = 1'b0;
    bit   acc;

    hamming_frame_decoder #(.CNT_W(C_CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_hamcode  (in_hamcode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .clr_stats   (clr_stats),
        .pcm_data    (pcm_data),
        .err_lo      (err_lo),
        .err_hi      (err_hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .corr_count  (corr_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Syndrome as the XOR of the 1-based positions of all set bits.
    function automatic exp_t ref_frame(input logic [13:0] f);
        exp_t       e;
        logic [6:0] w;
        logic [3:0] nib [2];
        logic       er  [2];
        int         syn;
        for (int h = 0; h < 2; h++) begin
            w   = f[h*7 +: 7];
            syn = 0;
            for (int i = 0; i < 7; i++) if (w[i]) syn ^= (i + 1);
            er[h] = (syn != 0);
            if (syn != 0) w[syn-1] = ~w[syn-1];
            nib[h] = {w[6], w[5], w[4], w[2]};
        end
        e.pcm = {nib[1], nib[0]};
        e.elo = er[0];
        e.ehi = er[1];
        return e;
    endfunction

    // One clock: settle the model for the last edge, check, then drive the next.
    task automatic cycle(input bit v, input logic [13:0] d, input bit ordy,
                         input bit clr, output bit accepted);
        int   now_entered;
        int   s1_cnt;
        exp_t e;
        @(negedge clk);
        if (pend_out) delivered++;
        if (pend_clr) m_frame = 0;
        else if (pend_out) m_frame = (m_frame + 1) % (C_CNT_MAX + 1);
        now_entered = delivered + (out_valid ? 1 : 0);
        for (int j = entered; j < now_entered && j < exp_q.size(); j++) begin
            if (!pend_clr) begin
                m_corr += int'(exp_q[j].elo) + int'(exp_q[j].ehi);
                if (m_corr > C_CNT_MAX) m_corr = C_CNT_MAX;
            end
        end
        entered = now_entered;
        if (pend_clr) m_corr = 0;
        check("corr_count", 32'(corr_count), 32'(m_corr));
        check("frame_count", 32'(frame_count), 32'(m_frame));
        if (out_valid) begin
            if (delivered < exp_q.size()) begin
                e = exp_q[delivered];
                check("pcm_data", 32'(pcm_data), 32'(e.pcm));
                check("err_lo", 32'(err_lo), 32'(e.elo));
                check("err_hi", 32'(err_hi), 32'(e.ehi));
            end else begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end
        end
        in_valid   = v;
        in_hamcode = d;
        out_ready  = ordy;
        clr_stats  = clr;
        #1;
        s1_cnt = exp_q.size() - entered;
        check("in_ready", 32'(in_ready), 32'((s1_cnt == 0) || !out_valid || ordy));
        accepted = v && in_ready;
        pend_out = out_valid && ordy;
        pend_clr = clr;
        if (accepted) exp_q.push_back(ref_frame(d));
    endtask

    task automatic send_one(input logic [13:0] d);
        cycle(1'b1, d, 1'b1, 1'b0, acc);
        cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);
        cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pcm", 32'(pcm_data), 32'd0);
        check("rst_err", 32'({err_hi, err_lo}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        send_one(14'h292D);
        check("clean_valid", 32'(out_valid), 32'd1);
        check("clean_pcm", 32'(pcm_data), 32'hA5);
        check("clean_err", 32'({err_hi, err_lo}), 32'd0);
        send_one(14'h293D);
        check("lo_err_pcm", 32'(pcm_data), 32'hA5);
        check("lo_err_flags", 32'({err_hi, err_lo}), 32'b01);
        check("lo_err_corr", 32'(corr_count), 32'd1);
        send_one(14'h29BD);
        check("dbl_flags", 32'({err_hi, err_lo}), 32'b11);
        check("dbl_corr", 32'(corr_count), 32'd3);
        send_one(14'h29BD);
        check("sat_corr", 32'(corr_count), 32'd3);

        cycle(1'b1, 14'h29BD, 1'b1, 1'b0, acc);
        cycle(1'b0, 14'd0, 1'b1, 1'b1, acc);
        cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);
        check("clr_corr", 32'(corr_count), 32'd0);
        check("clr_flags", 32'({err_hi, err_lo}), 32'b11);

        cycle(1'b1, 14'h0000, 1'b0, 1'b0, acc);
        cycle(1'b1, 14'h292D, 1'b0, 1'b0, acc);
        cycle(1'b1, 14'h293D, 1'b0, 1'b0, acc);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 14'h293D, 1'b0, 1'b0, acc);
        check("bp_hold_pcm", 32'(pcm_data), 32'h00);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) cycle(1'b1, 14'h293D, 1'b1, 1'b0, acc);
        check("bp_release_accept", 32'(acc), 32'd1);
        repeat (4) cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);
        check("bp_drained", 32'(delivered), 32'(exp_q.size()));

        for (int n = 0; n < 600; n++) begin
            cycle(($urandom % 4) != 0, 14'($urandom), ($urandom % 3) != 0,
                  ($urandom % 40) == 0, acc);
        end

        cycle(1'b1, 14'($urandom), 1'b0, 1'b0, acc);
        cycle(1'b1, 14'($urandom), 1'b0, 1'b0, acc);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_corr", 32'(corr_count), 32'd0);
        check("arst_frame", 32'(frame_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        delivered = 0;
        entered   = 0;
        m_corr    = 0;
        m_frame   = 0;
        pend_out  = 1'b0;
        pend_clr  = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);
        check("post_rst_no_out", 32'(delivered), 32'd0);
        send_one(14'h292D);
        check("post_rst_pcm", 32'(pcm_data), 32'hA5);
        cycle(1'b0, 14'd0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hamming_frame_decoder.md
Name: hamming_frame_decoder

Overview:
- Downstream consumer of the FSK demodulator's 14-bit Hamcode word. The word is two Hamming(7,4) codewords.
- Block checks syndromes, corrects single-bit errors and reassembles one 8-bit PCM sample for the PCM output stage.
- Two-stage pipeline with valid/ready on both sides, per-codeword error flags and statistics counters.
- Frames enter already synchronised to clk; the upstream synchroniser produces in_valid.

Parameters:
- CNT_W, 16, width of corr_count and frame_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_hamcode  input  14  [6:0] = low-nibble codeword, [13:7] = high-nibble codeword.
- in_valid  input  1  in_hamcode holds a frame.
- in_ready  output  1  block accepts a frame this cycle.
- clr_stats  input  1  synchronous clear of both counters.
- pcm_data  output  8  decoded sample, {hi nibble, lo nibble}.
- err_lo  output  1  low codeword had a nonzero syndrome and was corrected; aligned with pcm_data.
- err_hi  output  1  high codeword had a nonzero syndrome and was corrected; aligned with pcm_data.
- out_valid  output  1  pcm_data, err_lo and err_hi are valid.
- out_ready  input  1  downstream accepts.
- corr_count  output  CNT_W  saturating count of corrected codewords.
- frame_count  output  CNT_W  wrapping count of delivered frames.

Behaviour:
- Codeword layout, w[6:0]: w[0]=p1, w[1]=p2, w[2]=d1, w[3]=p4, w[4]=d2, w[5]=d3, w[6]=d4.
- Data nibble = {w6,w5,w4,w2}.
- Syndrome s = {s4,s2,s1}:
  - s1 = w0^w2^w4^w6
  - s2 = w1^w2^w5^w6
  - s4 = w3^w4^w5^w6
- s != 0: invert w[s-1] before data extraction and set that codeword's err flag. Double errors are not detected; every nonzero syndrome is treated as a single error.
- Stage 1 registers in_hamcode plus both 3-bit syndromes. Stage 2 registers the corrected pcm_data, err_lo and err_hi.
- Enables:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational; no dependency on in_valid)
- Transfers:
  - Frame is accepted on in_valid & in_ready.
  - Stage 1 moves to stage 2 when s1_valid & s2_en.
  - Output is consumed on out_valid & out_ready.
- Latency: 2 cycles from acceptance to out_valid when unstalled. Throughput is 1 frame per cycle.
- Stall: while out_valid & !out_ready, pcm_data, err_lo and err_hi hold stable. Stage 1 fills, then in_ready drops. No frame is lost or duplicated.
- corr_count:
  - Adds err_lo+err_hi (0..2) of the frame moving from stage 1 to stage 2.
  - Saturates at 2^CNT_W-1, including when an add of 2 would exceed it.
- frame_count: +1 on each output transfer; wraps to 0.
- clr_stats: both counters become 0 next cycle. Clear wins over a simultaneous increment. Pipeline contents are unaffected.
- Reset (async assert, any time including mid-frame): s1_valid=0, s2_valid=0, out_valid=0, pcm_data=0, err_lo=0, err_hi=0, corr_count=0, frame_count=0. Frames in flight are discarded.
- in_ready=1 whenever reset_n=1 and the pipeline is empty.
- No X propagation: data registers capture only on their enable.

Decomposition:
- Shared package hamfsk_pkg holds:
  - HAM_CW_W=7, HAM_FRAME_W=14, PCM_W=8
  - bit-position constants for p1/p2/d1/p4/d2/d3/d4
  - the same constants also serve the upstream encoder
- Sub-module hamming74_correct: combinational; 7-bit codeword in, 4-bit nibble and err flag out. Instantiated twice in stage 2. Syndrome logic lives inside it, and stage 1 uses the same functions from the package.

Test Plan:
- Clean frame, no stall: in_hamcode=0x292D, out_ready=1 -> 2 cycles later pcm_data=0xA5, err_lo=0, err_hi=0, corr_count=0, frame_count=1.
- Low single error: 0x293D (lo w[4] flipped, syndrome 5) -> pcm_data=0xA5, err_lo=1, err_hi=0, corr_count=1.
- Double-codeword error: 0x29BD (hi p1 flipped, lo w[4] flipped) -> pcm_data=0xA5, err_lo=1, err_hi=1, corr_count increases by 2.
- Backpressure: stream 0x0000, 0x292D, 0x293D back-to-back with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, pcm_data holds 0x00. On release the outputs are 0x00, 0xA5, 0xA5 in order, with no loss or duplication.
- Saturation and clear (CNT_W=2):
  - Feed 0x29BD twice -> corr_count=3 (saturated).
  - Assert clr_stats in the same cycle as a correcting transfer -> corr_count=0.
- Async reset with 2 frames in flight -> out_valid=0 and counters=0 immediately. After release, in_ready=1 and no stale frame is emitted.
